// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising checker for the 32-bit Galois LFSR stream.
// Seeds from the stream, counts correct predictions up to lock, then runs as a flywheel and counts mismatches.
module lfsr_stream_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_in,
  input  logic             data_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);
  localparam logic [1:0] HUNT   = 2'b00;
  localparam logic [1:0] VERIFY = 2'b01;
  localparam logic [1:0] LOCKED = 2'b10;
  function automatic logic [31:0] nxt(input logic [31:0] d);
    return {d[30:0], d[31]} ^ (d[31] ? 32'h0000_00AE : 32'h0);
  endfunction
  logic [1:0]       r_state;
  logic [31:0]      r_exp;
  logic [3:0]       r_good;
  logic [3:0]       r_bad;
  logic             r_err;
  logic [ERR_W-1:0] r_cnt;
  logic             w_match;
  logic             w_nz;
  logic             w_miss;
  logic [3:0]       w_good_inc;
  logic [3:0]       w_bad_inc;
  assign w_match    = data_in == r_exp;
  assign w_nz       = |data_in;
  assign w_miss     = data_valid && r_state == LOCKED && !w_match;
  assign w_good_inc = r_good + 4'd1;
  assign w_bad_inc  = r_bad + 4'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_exp   <= '0;
      r_good  <= '0;
      r_bad   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_miss;
      if (data_valid) begin
        case (r_state)
          HUNT: if (w_nz) begin
            r_exp   <= nxt(data_in);
            r_good  <= '0;
            r_state <= VERIFY;
          end
          VERIFY: if (w_match) begin
            r_exp  <= nxt(data_in);
            r_good <= w_good_inc;
            if (w_good_inc == 4'(LOCK_CNT)) begin
              r_state <= LOCKED;
              r_bad   <= '0;
            end
          end else if (w_nz) begin
            r_exp  <= nxt(data_in);
            r_good <= '0;
          end else begin
            r_state <= HUNT;
          end
          LOCKED: begin
            // flywheel: prediction advances from its own state, never from the input
            r_exp <= nxt(r_exp);
            r_bad <= w_match ? 4'd0 : w_bad_inc;
            if (!w_match && w_bad_inc == 4'(UNLOCK_CNT)) r_state <= HUNT;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (clr_cnt) r_cnt <= '0;
    else if (w_miss && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end
  assign locked  = r_state == LOCKED;
  assign err     = r_err;
  assign err_cnt = r_cnt;
  assign state   = r_state;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: directed stimulus against a behavioural model, plus literal pins at key points.
module tb_lfsr_stream_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err, locked2, err2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;
  logic [1:0]  state, state2;
  int          n_err = 0;
  int          n_chk = 0;
  int          m_st, m_good, m_bad, m_cnt;
  bit          m_err;
  logic [31:0] m_exp, g;

  lfsr_stream_checker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt), .state(state)
  );
  lfsr_stream_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr_cnt(clr_cnt),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2), .state(state2)
  );

  always #5 clk = ~clk;

  // polynomial step as a left shift with the full feedback tap set (includes bit 0)
  function automatic logic [31:0] lfsr_next(input logic [31:0] d);
    return (d << 1) ^ (d[31] ? 32'h0000_00AF : 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int sat2;
    sat2 = m_cnt > 3 ? 3 : m_cnt;
    check("state", {30'd0, state}, m_st);
    check("locked", {31'd0, locked}, {31'd0, m_st == 2});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("err_cnt", {16'd0, err_cnt}, m_cnt > 65535 ? 65535 : m_cnt);
    check("err_cnt_w2", {30'd0, err_cnt2}, sat2);
    check("err_w2", {31'd0, err2}, {31'd0, m_err});
  endtask

  task automatic model(input bit v, input logic [31:0] d, input bit clr);
    m_err = 0;
    if (v) begin
      if (m_st == 0) begin
        if (d != 0) begin m_exp = lfsr_next(d); m_good = 0; m_st = 1; end
      end else if (m_st == 1) begin
        if (d == m_exp) begin
          m_exp = lfsr_next(d);
          m_good++;
          if (m_good == 4) begin m_st = 2; m_bad = 0; end
        end else if (d != 0) begin
          m_exp = lfsr_next(d);
          m_good = 0;
        end else m_st = 0;
      end else begin
        if (d == m_exp) m_bad = 0;
        else begin
          m_err = 1;
          m_cnt++;
          m_bad++;
          if (m_bad == 3) m_st = 0;
        end
        m_exp = lfsr_next(m_exp);
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit clr);
    data_valid = v;
    data_in = d;
    clr_cnt = clr;
    @(posedge clk);
    model(v, d, clr);
    #1 check_all();
  endtask

  task automatic send_good();
    step(1, g, 0);
    g = lfsr_next(g);
  endtask

  task automatic send_bad(input bit clr);
    step(1, g ^ 32'h1, clr);
    g = lfsr_next(g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_st = 0; m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_err = 0;
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    data_valid = 0;
    #2 do_reset();
    // VERIFY re-seed on nonzero mismatch, then a zero word drops back to HUNT
    step(1, 32'h5, 0);
    step(1, 32'h7, 0);
    step(1, 32'hE, 0);
    check("verify_hold", {30'd0, state}, 32'd1);
    step(1, 32'h0, 0);
    check("zero_to_hunt", {30'd0, state}, 32'd0);
    // test 1: clean stream from seed 1
    g = 32'h1;
    for (int i = 0; i < 5; i++) send_good();
    check("lock_5th", {31'd0, locked}, 32'd1);
    while (g != 32'h100) send_good();
    // test 2: single corrupted word
    send_bad(0);
    check("single_err_cnt", {16'd0, err_cnt}, 32'd1);
    check("single_err", {31'd0, err}, 32'd1);
    send_good();
    check("recover_err", {31'd0, err}, 32'd0);
    step(0, 32'hDEAD_BEEF, 1);
    check("clr_idle", {16'd0, err_cnt}, 32'd0);
    // test 3: three corrupted words unlock
    for (int i = 0; i < 3; i++) send_bad(0);
    check("unlock_state", {30'd0, state}, 32'd0);
    check("unlock_cnt", {16'd0, err_cnt}, 32'd3);
    for (int i = 0; i < 5; i++) send_good();
    check("relock", {31'd0, locked}, 32'd1);
    // test 4: zeros ignored in HUNT
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h0, 0);
    check("zeros_hunt", {30'd0, state}, 32'd0);
    g = 32'h8000_0000;
    send_good();
    send_good();
    check("af_match", {30'd0, state}, 32'd1);
    for (int i = 0; i < 3; i++) send_good();
    check("lock_after_af", {31'd0, locked}, 32'd1);
    // test 5: idle cycles hold the prediction
    for (int i = 0; i < 3; i++) begin
      send_good();
      step(0, 32'h1234_5678, 0);
      step(0, 32'h0, 0);
    end
    check("idle_lock", {31'd0, locked}, 32'd1);
    // test 6: saturation (2-bit instance) and clear priority
    for (int i = 0; i < 2; i++) send_bad(0);
    send_good();
    for (int i = 0; i < 2; i++) send_bad(0);
    check("sat_w2", {30'd0, err_cnt2}, 32'd3);
    check("sat_main", {16'd0, err_cnt}, 32'd4);
    send_good();
    send_bad(1);
    check("clr_prio_cnt", {16'd0, err_cnt}, 32'd0);
    check("clr_prio_err", {31'd0, err}, 32'd1);
    send_good();
    #3 do_reset();
    check("rst_state", {30'd0, state}, 32'd0);
    send_good();
    check("post_rst", {30'd0, state}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive side of the team's 32-bit Galois LFSR random source: takes the raw LFSR state word stream, self-synchronises to it, and predicts each following word.
- Flags mismatches and keeps a saturating error count.
- Sits at the consumer end of a random-stream link; used in BIST and bring-up to prove the generator and the path between the two blocks.

Parameters:
LOCK_CNT, 4, consecutive correct predictions required in VERIFY before entering LOCKED (1..15)
UNLOCK_CNT, 3, consecutive mismatches in LOCKED that force return to HUNT (1..15)
ERR_W, 16, width of the error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
data_in  input  32  received LFSR state word
data_valid  input  1  data_in qualifier, one word per high cycle
clr_cnt  input  1  synchronous clear of err_cnt
locked  output  1  checker is synchronised (state LOCKED)
err  output  1  one-cycle pulse: last valid word mismatched while LOCKED
err_cnt  output  ERR_W  saturating mismatch count
state  output  2  00 HUNT, 01 VERIFY, 10 LOCKED

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Reset forces state=HUNT, locked=0, err=0, err_cnt=0, expected word=0, both run counters=0.
- Next-state function, the same polynomial as the generator (x^32+x^7+x^5+x^3+x^2+x+1):
  - nxt(d) = {d[30:0], d[31]} XOR (d[31] ? 32'h000000AE : 0).
- Cycles with data_valid=0 change nothing: state, expected word and counters hold. err is 0 on those cycles.
- HUNT:
  - A valid word that is nonzero loads exp <= nxt(data_in) and good_run <= 0, then goes to VERIFY.
  - A valid word of zero (the LFSR lock-up value) is ignored, and the checker stays in HUNT.
- VERIFY:
  - Match (data_in==exp): exp <= nxt(data_in), good_run++. If good_run reaches LOCK_CNT, go to LOCKED with bad_run <= 0.
  - Mismatch with nonzero data: re-seed exp <= nxt(data_in), good_run <= 0, stay in VERIFY.
  - Mismatch with zero data: go to HUNT.
  - err is never asserted in VERIFY.
- LOCKED (flywheel: never re-seeds from input):
  - Match: exp <= nxt(exp), bad_run <= 0.
  - Mismatch: err=1 for one cycle, err_cnt++ (saturates at all-ones, no wrap), exp <= nxt(exp), bad_run++.
  - When bad_run reaches UNLOCK_CNT, go to HUNT. The UNLOCK_CNT-th mismatch is itself counted and pulses err.
- Latency: err, err_cnt, locked and state are registered and update on the clock edge that samples the word.
  - locked rises on the edge that samples the LOCK_CNT-th consecutive match.
- clr_cnt:
  - Zeroes err_cnt on the next edge and takes priority over an increment in the same cycle. The err pulse still fires.
  - It does not affect state, exp, or the run counters.
- Reset mid-stream: aborts immediately; the next valid nonzero word restarts HUNT.
- Width rule: run counters are 4 bits; comparisons are exact equality with the parameter value.

Test Plan:
1. Reset, then valid stream starting at seed 0x00000001 (0x1, 0x2, 0x4, ... , 0x80000000, 0x000000AF) -> state HUNT→VERIFY; locked=1 on the edge sampling the 5th word (1 seed + 4 matches); err never asserted, err_cnt=0.
2. Locked on the stream above, corrupt one word (0x00000100 sent as 0x00000101) -> err single-cycle pulse, err_cnt=1, locked stays 1. The next correct word (0x00000200) matches with no further err.
3. Locked, then 3 consecutive corrupt words -> err_cnt=3, state returns to HUNT after the 3rd. Then the clean stream resumes and relocks after 5 valid words.
4. In HUNT, send 0x00000000 three times, then 0x80000000 followed by 0x000000AF -> zeros ignored (state stays HUNT); 0x80000000 seeds VERIFY, and 0x000000AF counts as the first match.
5. Locked stream with data_valid toggling 1,0,0,1 -> idle cycles hold exp; no false err; lock is kept.
6. Force err_cnt to 0xFFFF (ERR_W=16) and inject a mismatch with clr_cnt=0 -> stays 0xFFFF. Then mismatch with clr_cnt=1 in the same cycle -> err_cnt=0, err=1. Assert rst mid-stream -> all outputs 0 and state=HUNT, asynchronously.
